seg_decoder: RTL and testbench

SEG_DECODER -- requirements
Module: seg_decoder

---
 rtl/seg_decoder.sv | 147 ++++++++++++++
 tb/tb_seg_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decoder.sv
// seg_decoder: recovers four digits from a scanned, active-low, multiplexed 7-segment display bus.
// Define SEG_DECODER_HEX_EN to also decode the hex letters A..F; without it they decode as errors.
module seg_decoder #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clkIn,
    input  logic        rstNIn,
    input  logic [6:0]  segIn,
    input  logic        decimalIn,
    input  logic [3:0]  anodeIn,
    output logic [19:0] digitsOut,
    output logic [3:0]  dpOut,
    output logic        validOut,
    output logic        errorOut
);

    localparam logic [7:0] RUN_MAX    = 8'(STABLE_CNT);
    localparam logic [7:0] RUN_PRE    = 8'(STABLE_CNT - 1);
    localparam logic [4:0] CODE_BLANK = 5'd31;
    localparam logic [4:0] CODE_ERR   = 5'd30;

    // Exactly one active-low select line means a real digit is being driven.
    function automatic logic anodeValid(input logic [3:0] anode);
        logic ok;
        case (anode)
            4'hE, 4'hD, 4'hB, 4'h7: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] anodeIndex(input logic [3:0] anode);
        logic [1:0] idx;
        case (anode)
            4'hD:    idx = 2'd1;
            4'hB:    idx = 2'd2;
            4'h7:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] runSatInc(input logic [7:0] cnt);
        logic [7:0] res;
        if (cnt >= RUN_MAX) res = RUN_MAX;
        else                res = cnt + 8'd1;
        return res;
    endfunction

    // Returns {unknown, code}; blank is a legal pattern, not an error.
    function automatic logic [5:0] decodeSeg(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h40:   res = {1'b0, 5'd0};
            7'h79:   res = {1'b0, 5'd1};
            7'h24:   res = {1'b0, 5'd2};
            7'h30:   res = {1'b0, 5'd3};
            7'h19:   res = {1'b0, 5'd4};
            7'h12:   res = {1'b0, 5'd5};
            7'h02:   res = {1'b0, 5'd6};
            7'h78:   res = {1'b0, 5'd7};
            7'h00:   res = {1'b0, 5'd8};
            7'h10:   res = {1'b0, 5'd9};
`ifdef SEG_DECODER_HEX_EN
            7'h08:   res = {1'b0, 5'd10};
            7'h03:   res = {1'b0, 5'd11};
            7'h46:   res = {1'b0, 5'd12};
            7'h21:   res = {1'b0, 5'd13};
            7'h06:   res = {1'b0, 5'd14};
            7'h0E:   res = {1'b0, 5'd15};
`endif
            7'h7F:   res = {1'b0, CODE_BLANK};
            default: res = {1'b1, CODE_ERR};
        endcase
        return res;
    endfunction

    logic [11:0] sampleKey;
    logic [11:0] sample_p0;
    logic [7:0]  runCnt_p0;
    logic [7:0]  runNext;
    logic        selValid;
    logic        sameAsSample;
    logic        captureEn;
    logic [1:0]  capIdx;
    logic [3:0]  capBit;
    logic [5:0]  decoded;
    logic [3:0]  capMask_p1;
    logic [3:0]  maskMerged;
    logic        frameDone;
    logic [19:0] digitsNext;
    logic [3:0]  dpNext;

    // Stage 0: run-length tracking against the previous sample
    assign sampleKey    = {anodeIn, segIn, decimalIn};
    assign selValid     = anodeValid(anodeIn);
    assign sameAsSample = (sampleKey == sample_p0);

    always_comb begin
        runNext = 8'd1;
        if (!selValid)         runNext = 8'd0;
        else if (sameAsSample) runNext = runSatInc(runCnt_p0);
    end

    // Only the transition into saturation captures, so one stable run yields one capture.
    assign captureEn  = (runCnt_p0 == RUN_PRE) && (runNext == RUN_MAX);
    assign capIdx     = anodeIndex(anodeIn);
    assign capBit     = 4'b0001 << capIdx;
    assign decoded    = decodeSeg(segIn);
    assign maskMerged = capMask_p1 | capBit;
    assign frameDone  = captureEn && (maskMerged == 4'hF);

    // Stage 1: slot update and frame tracking
    always_comb begin
        digitsNext = digitsOut;
        dpNext     = dpOut;
        for (int i = 0; i < 4; i++) begin
            if (captureEn && (capIdx == 2'(i))) begin
                digitsNext[5*i +: 5] = decoded[4:0];
                dpNext[i]            = ~decimalIn;
            end
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            sample_p0  <= '1;
            runCnt_p0  <= '0;
            capMask_p1 <= '0;
            digitsOut  <= '1;
            dpOut      <= '0;
            validOut   <= 1'b0;
            errorOut   <= 1'b0;
        end else begin
            sample_p0 <= sampleKey;
            runCnt_p0 <= runNext;
            digitsOut <= digitsNext;
            dpOut     <= dpNext;
            validOut  <= frameDone;
            errorOut  <= captureEn && decoded[5];
            if (captureEn) begin
                capMask_p1 <= frameDone ? 4'h0 : maskMerged;
            end
        end
    end

endmodule

// File: tb/tb_seg_decoder.sv
// tb_seg_decoder: scoreboard bench for seg_decoder; expected pulses are queued as stimulus is applied.
`timescale 1ns/1ps
module tb_seg_decoder;

    localparam int SC = 4;
    localparam logic [6:0] PATS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clkIn = 1'b0;
    logic        rstNIn;
    logic [6:0]  segIn;
    logic        decimalIn;
    logic [3:0]  anodeIn;
    logic [19:0] digitsOut;
    logic [3:0]  dpOut;
    logic        validOut;
    logic        errorOut;

    seg_decoder #(.STABLE_CNT(SC)) dut (
        .clkIn     (clkIn),
        .rstNIn    (rstNIn),
        .segIn     (segIn),
        .decimalIn (decimalIn),
        .anodeIn   (anodeIn),
        .digitsOut (digitsOut),
        .dpOut     (dpOut),
        .validOut  (validOut),
        .errorOut  (errorOut)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        bit          isErr;
        int unsigned cyc;
        logic [19:0] digits;
    } expEv_t;

    expEv_t      expQ[$];
    int unsigned cycCnt = 0;
    int          vecCnt = 0;
    int          missCnt = 0;
    logic [19:0] expDigits;
    logic [3:0]  expDp;
    logic [3:0]  expMask;
    logic [11:0] prevKey;
    logic [19:0] snapDigits;

    always @(posedge clkIn) cycCnt <= cycCnt + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            missCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] refDecode(input logic [6:0] s);
        int lim = 10;
`ifdef SEG_DECODER_HEX_EN
        lim = 16;
`endif
        if (s == 7'h7F) return {1'b0, 5'd31};
        for (int i = 0; i < lim; i++)
            if (PATS[i] == s) return {1'b0, 5'(i)};
        return {1'b1, 5'd30};
    endfunction

    function automatic int refSlot(input logic [3:0] a);
        case (a)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    // Called at a falling edge; applies one input value for n clock cycles.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        logic [11:0] key;
        logic [5:0]  dec;
        logic [3:0]  merged;
        int          pos;
        int unsigned capCyc;
        anodeIn   = a;
        segIn     = s;
        decimalIn = d;
        key = {a, s, d};
        pos = refSlot(a);
        if (pos >= 0 && n >= SC && key != prevKey) begin
            capCyc = cycCnt + SC;
            dec = refDecode(s);
            expDigits[pos*5 +: 5] = dec[4:0];
            expDp[pos] = ~d;
            merged = expMask | (4'b0001 << pos);
            if (merged == 4'hF) begin
                expQ.push_back('{1'b0, capCyc, expDigits});
                expMask = 4'h0;
            end else begin
                expMask = merged;
            end
            if (dec[5]) expQ.push_back('{1'b1, capCyc, expDigits});
        end
        prevKey = key;
        repeat (n) @(negedge clkIn);
        checkVal("digitsShadow", {12'h0, digitsOut}, {12'h0, expDigits});
        checkVal("dpShadow", {28'h0, dpOut}, {28'h0, expDp});
    endtask

    always @(negedge clkIn) begin
        expEv_t ev;
        if (validOut) begin
            if (expQ.size() == 0 || expQ[0].isErr) begin
                checkVal("unexpectedValid", 32'd1, 32'd0);
            end else begin
                ev = expQ.pop_front();
                checkVal("validCycle", cycCnt, ev.cyc);
                checkVal("validDigits", {12'h0, digitsOut}, {12'h0, ev.digits});
            end
        end
        if (errorOut) begin
            if (expQ.size() == 0 || !expQ[0].isErr) begin
                checkVal("unexpectedError", 32'd1, 32'd0);
            end else begin
                ev = expQ.pop_front();
                checkVal("errorCycle", cycCnt, ev.cyc);
            end
        end
    end

    initial begin
        rstNIn    = 1'b0;
        anodeIn   = 4'hF;
        segIn     = 7'h7F;
        decimalIn = 1'b1;
        expDigits = '1;
        expDp     = '0;
        expMask   = '0;
        prevKey   = '1;

        repeat (3) @(negedge clkIn);
        checkVal("rstDigits", {12'h0, digitsOut}, 32'h000F_FFFF);
        checkVal("rstDp", {28'h0, dpOut}, 32'd0);
        checkVal("rstValid", {31'h0, validOut}, 32'd0);
        checkVal("rstError", {31'h0, errorOut}, 32'd0);
        #2 rstNIn = 1'b1;
        @(negedge clkIn);

        // Stable scan of positions 0..3 showing 1,2,3,4
        hold(4'hE, 7'h79, 1'b1, 6);
        hold(4'hD, 7'h24, 1'b1, 6);
        hold(4'hB, 7'h30, 1'b1, 6);
        hold(4'h7, 7'h19, 1'b1, 6);
        checkVal("scanDigits", {12'h0, digitsOut}, 32'h0002_0C41);
        checkVal("scanDp", {28'h0, dpOut}, 32'd0);

        // Glitch: an 8 held one cycle short of a capture, then a stable 9
        hold(4'hE, 7'h00, 1'b1, SC - 1);
        checkVal("glitchNoWrite", {27'h0, digitsOut[4:0]}, 32'd1);
        hold(4'hE, 7'h10, 1'b1, SC);
        checkVal("glitchSlot0", {27'h0, digitsOut[4:0]}, 32'd9);

        // Unknown pattern on position 2, then a hex letter recapture
        hold(4'hB, 7'h55, 1'b1, 6);
        checkVal("unknownSlot2", {27'h0, digitsOut[14:10]}, 32'd30);
        hold(4'hB, 7'h08, 1'b1, 6);
`ifdef SEG_DECODER_HEX_EN
        checkVal("hexSlot2", {27'h0, digitsOut[14:10]}, 32'd10);
`else
        checkVal("hexSlot2", {27'h0, digitsOut[14:10]}, 32'd30);
`endif

        // Invalid select: two lines low at once
        snapDigits = expDigits;
        hold(4'hC, 7'h00, 1'b1, 20);
        checkVal("invalidHold", {12'h0, digitsOut}, {12'h0, snapDigits});

        // Blank digit with its decimal point lit
        hold(4'h7, 7'h7F, 1'b0, 6);
        checkVal("blankSlot3", {27'h0, digitsOut[19:15]}, 32'd31);
        checkVal("blankDp3", {31'h0, dpOut[3]}, 32'd1);

        // Position 1 completes the frame
        hold(4'hD, 7'h02, 1'b1, 6);
        checkVal("frameSlot1", {27'h0, digitsOut[9:5]}, 32'd6);

        // Reset between clock edges in the middle of a frame
        hold(4'hE, 7'h78, 1'b1, 6);
        hold(4'hD, 7'h12, 1'b1, 6);
        checkVal("preRstSlot1", {27'h0, digitsOut[9:5]}, 32'd5);
        #2 rstNIn = 1'b0;
        #1;
        checkVal("asyncRstDigits", {12'h0, digitsOut}, 32'h000F_FFFF);
        checkVal("asyncRstDp", {28'h0, dpOut}, 32'd0);
        expDigits = '1;
        expDp     = '0;
        expMask   = '0;
        #1 rstNIn = 1'b1;
        @(negedge clkIn);
        hold(4'hB, 7'h40, 1'b1, 6);
        hold(4'h7, 7'h00, 1'b0, 6);
        hold(4'hE, 7'h79, 1'b1, 6);
        hold(4'hD, 7'h24, 1'b0, 6);
        checkVal("postRstDigits", {12'h0, digitsOut}, 32'h0004_0041);

        // Frame completed by an unknown pattern: valid and error on the same edge
        hold(4'hE, 7'h40, 1'b1, 5);
        hold(4'hD, 7'h79, 1'b1, 5);
        hold(4'hB, 7'h24, 1'b1, 5);
        hold(4'h7, 7'h55, 1'b1, 5);

        hold(4'hF, 7'h7F, 1'b1, 8);
        checkVal("queueDrained", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
